// File: rtl/cp_correlator.sv
// Sliding-window cyclic-prefix correlator with peak-confirm symbol-timing FSM.
// Four register levels: input capture, conj product, window accumulate, magnitude/output.
module cp_correlator #(
  parameter int DATA_WIDTH = 16,
  parameter int FFT_LENGTH = 64,
  parameter int CP_LENGTH  = 16,
  parameter int ACC_WIDTH  = DATA_WIDTH + 1 + $clog2(CP_LENGTH)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  input  logic [DATA_WIDTH-1:0]       data_cur,
  input  logic [DATA_WIDTH-1:0]       data_dly,
  input  logic [ACC_WIDTH:0]          threshold,
  output logic signed [ACC_WIDTH-1:0] corr_re,
  output logic signed [ACC_WIDTH-1:0] corr_im,
  output logic [ACC_WIDTH:0]          corr_mag,
  output logic                        corr_valid,
  output logic                        sym_start,
  output logic [ACC_WIDTH:0]          peak_mag
);

  localparam int HW     = DATA_WIDTH / 2;
  localparam int PW     = DATA_WIDTH + 1;
  localparam int STAGES = 3;
  localparam int WARM   = FFT_LENGTH + CP_LENGTH;
  localparam int WCW    = $clog2(WARM);
  localparam int HALF   = CP_LENGTH / 2;
  localparam int CW     = $clog2(HALF) + 1;
  localparam int BW     = $clog2(FFT_LENGTH) + 1;

  typedef enum logic [1:0] {SEARCH, TRACK, HOLD} state_t;

  function automatic logic signed [PW-1:0] sx(input logic [HW-1:0] v);
    return {{(PW-HW){v[HW-1]}}, v};
  endfunction

  function automatic logic signed [ACC_WIDTH-1:0] ax(input logic [PW-1:0] v);
    return {{(ACC_WIDTH-PW){v[PW-1]}}, v};
  endfunction

  logic [STAGES:0]                    vld_pipe;
  logic [STAGES:0]                    warm_pipe;
  logic [WCW-1:0]                     smp_cnt;
  logic [DATA_WIDTH-1:0]              cur_q, dly_q;
  logic signed [PW-1:0]               p_re_c, p_im_c, p_re_q, p_im_q;
  logic [CP_LENGTH-1:0][PW-1:0]       hist_re, hist_im;
  logic [CP_LENGTH-1:0]               hist_v;
  logic [PW-1:0]                      old_re, old_im;
  logic signed [ACC_WIDTH-1:0]        acc_re, acc_im;
  logic [ACC_WIDTH-1:0]               abs_re, abs_im;

  state_t                             state;
  logic [ACC_WIDTH:0]                 peak_reg;
  logic [CW-1:0]                      cnt;
  logic [BW-1:0]                      blank;

  // Input capture; warm tag marks samples once delay line and window are both primed.
  always_ff @(posedge clk) begin
    if (!rst) begin
      vld_pipe  <= '0;
      warm_pipe <= '0;
      smp_cnt   <= '0;
      cur_q     <= '0;
      dly_q     <= '0;
    end else begin
      vld_pipe  <= {vld_pipe[STAGES-1:0], in_valid};
      warm_pipe <= {warm_pipe[STAGES-1:0], in_valid && (smp_cnt == WCW'(WARM-1))};
      if (in_valid) begin
        cur_q <= data_cur;
        dly_q <= data_dly;
        if (smp_cnt != WCW'(WARM-1)) smp_cnt <= smp_cnt + 1'b1;
      end
    end
  end

  // x[n-N] * conj(x[n]), full precision
  always_comb begin
    p_re_c = sx(dly_q[DATA_WIDTH-1:HW]) * sx(cur_q[DATA_WIDTH-1:HW])
           + sx(dly_q[HW-1:0])          * sx(cur_q[HW-1:0]);
    p_im_c = sx(dly_q[HW-1:0])          * sx(cur_q[DATA_WIDTH-1:HW])
           - sx(dly_q[DATA_WIDTH-1:HW]) * sx(cur_q[HW-1:0]);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      p_re_q <= '0;
      p_im_q <= '0;
    end else if (vld_pipe[0]) begin
      p_re_q <= p_re_c;
      p_im_q <= p_im_c;
    end
  end

  // Oldest product only leaves the sum once the window has actually filled.
  assign old_re = hist_v[CP_LENGTH-1] ? hist_re[CP_LENGTH-1] : '0;
  assign old_im = hist_v[CP_LENGTH-1] ? hist_im[CP_LENGTH-1] : '0;

  always_ff @(posedge clk) begin
    if (!rst) begin
      hist_re <= '0;
      hist_im <= '0;
      hist_v  <= '0;
      acc_re  <= '0;
      acc_im  <= '0;
    end else if (vld_pipe[1]) begin
      hist_re <= {hist_re[CP_LENGTH-2:0], p_re_q};
      hist_im <= {hist_im[CP_LENGTH-2:0], p_im_q};
      hist_v  <= {hist_v[CP_LENGTH-2:0], 1'b1};
      acc_re  <= acc_re + ax(p_re_q) - ax(old_re);
      acc_im  <= acc_im + ax(p_im_q) - ax(old_im);
    end
  end

  assign abs_re = acc_re[ACC_WIDTH-1] ? -acc_re : acc_re;
  assign abs_im = acc_im[ACC_WIDTH-1] ? -acc_im : acc_im;

  always_ff @(posedge clk) begin
    if (!rst) begin
      corr_re  <= '0;
      corr_im  <= '0;
      corr_mag <= '0;
    end else if (vld_pipe[2] && warm_pipe[2]) begin
      corr_re  <= acc_re;
      corr_im  <= acc_im;
      corr_mag <= {1'b0, abs_re} + {1'b0, abs_im};
    end
  end

  assign corr_valid = vld_pipe[STAGES] & warm_pipe[STAGES];

  // Peak confirm: HALF non-improving outputs after the max, then FFT_LENGTH outputs blanked.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= SEARCH;
      peak_reg  <= '0;
      cnt       <= '0;
      blank     <= '0;
      sym_start <= 1'b0;
      peak_mag  <= '0;
    end else begin
      sym_start <= 1'b0;
      if (corr_valid) begin
        case (state)
          SEARCH: begin
            if (corr_mag > threshold) begin
              state    <= TRACK;
              peak_reg <= corr_mag;
              cnt      <= '0;
            end
          end
          TRACK: begin
            if (corr_mag > peak_reg) begin
              peak_reg <= corr_mag;
              cnt      <= '0;
            end else if (cnt == CW'(HALF-1)) begin
              sym_start <= 1'b1;
              peak_mag  <= peak_reg;
              state     <= HOLD;
              blank     <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          HOLD: begin
            if (blank == BW'(FFT_LENGTH-1)) state <= SEARCH;
            else                            blank <= blank + 1'b1;
          end
          default: state <= SEARCH;
        endcase
      end
    end
  end

endmodule
